// File: rtl/synth_pkg.sv
// Shared synth front-panel types and width helpers.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE   = 2'd0,
    TRIANGLE = 2'd1,
    SAWTOOTH = 2'd2,
    SINE     = 2'd3
  } wave_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop sync, debounce, press edge detect and optional hold auto-repeat.
module button_conditioner
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic btn_event
);

  localparam int DB_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam int HOLD_W = clog2_min1(REPEAT_DELAY + REPEAT_PERIOD);

  logic              sync1;
  logic              sync2;
  logic [DB_W-1:0]   db_cnt;
  logic [1:0]        fill;
  logic              armed;
  logic              holding;
  logic [HOLD_W-1:0] hold_cnt;
  logic              toggle;
  logic              rise_ok;
  logic [HOLD_W-1:0] hold_next;

  // Debounce terminal count, qualified press, and the wrapping repeat counter.
  always_comb begin
    toggle  = (sync2 != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    rise_ok = toggle && !level && armed;
    if (hold_cnt == HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD - 1)) begin
      hold_next = HOLD_W'(REPEAT_DELAY);
    end else begin
      hold_next = hold_cnt + HOLD_W'(1);
    end
  end

  // A press only counts once the synced input has been seen low after reset,
  // so a button held through reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= {DB_W{1'b0}};
      level     <= 1'b0;
      fill      <= 2'd0;
      armed     <= 1'b0;
      holding   <= 1'b0;
      hold_cnt  <= {HOLD_W{1'b0}};
      btn_event <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (fill != 2'd2) begin
        fill <= fill + 2'd1;
      end else if (!sync2) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        db_cnt <= {DB_W{1'b0}};
      end else if (toggle) begin
        db_cnt <= {DB_W{1'b0}};
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (rise_ok) begin
        holding   <= 1'b1;
        hold_cnt  <= {HOLD_W{1'b0}};
        btn_event <= 1'b1;
      end else if (toggle && level) begin
        holding   <= 1'b0;
        hold_cnt  <= {HOLD_W{1'b0}};
        btn_event <= 1'b0;
      end else if ((REPEAT_DELAY > 0) && holding) begin
        hold_cnt  <= hold_next;
        btn_event <= (hold_next == HOLD_W'(REPEAT_DELAY));
      end else begin
        btn_event <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/waveform_select_multi.sv
// Per-voice waveform selector: three conditioned buttons drive a per-channel waveform register array.
module waveform_select_multi
  import synth_pkg::*;
#(
  parameter int  NUM_WAVES       = 3,
  parameter int  NUM_CHANNELS    = 4,
  parameter int  WRAP            = 1,
  parameter int  DEBOUNCE_CYCLES = 100000,
  parameter int  REPEAT_DELAY    = 0,
  parameter int  REPEAT_PERIOD   = 25000,
  localparam int WAVE_W          = clog2_min1(NUM_WAVES),
  localparam int CH_W            = clog2_min1(NUM_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           next_btn,
  input  logic                           prev_btn,
  input  logic                           chan_btn,
  output logic [NUM_CHANNELS*WAVE_W-1:0] waveform_out,
  output logic [CH_W-1:0]                active_chan,
  output logic                           changed
);

  logic              next_evt;
  logic              prev_evt;
  logic              chan_evt;
  logic              next_level;
  logic              prev_level;
  logic              chan_level;
  logic              unused_levels;
  logic [WAVE_W-1:0] wave     [NUM_CHANNELS];
  logic [WAVE_W-1:0] wave_nxt [NUM_CHANNELS];
  logic [CH_W-1:0]   chan_nxt;
  logic              step_up;
  logic              step_dn;
  logic              diff;

  assign unused_levels = next_level & prev_level & chan_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_next (
    .clk(clk), .rst(rst), .btn_raw(next_btn), .level(next_level), .btn_event(next_evt)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_prev (
    .clk(clk), .rst(rst), .btn_raw(prev_btn), .level(prev_level), .btn_event(prev_evt)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_chan (
    .clk(clk), .rst(rst), .btn_raw(chan_btn), .level(chan_level), .btn_event(chan_evt)
  );

  function automatic logic [WAVE_W-1:0] wave_step(input logic [WAVE_W-1:0] cur, input logic up);
    logic [WAVE_W-1:0] r;
    if (up) begin
      if (cur == WAVE_W'(NUM_WAVES - 1)) begin
        r = (WRAP != 0) ? {WAVE_W{1'b0}} : cur;
      end else begin
        r = cur + WAVE_W'(1);
      end
    end else begin
      if (cur == {WAVE_W{1'b0}}) begin
        r = (WRAP != 0) ? WAVE_W'(NUM_WAVES - 1) : cur;
      end else begin
        r = cur - WAVE_W'(1);
      end
    end
    return r;
  endfunction

  // Event arbitration: a wave step targets the pre-update active channel.
  always_comb begin
    step_up = ena && next_evt && !prev_evt;
    step_dn = ena && prev_evt && !next_evt;
    if (ena && chan_evt) begin
      chan_nxt = (active_chan == CH_W'(NUM_CHANNELS - 1)) ? {CH_W{1'b0}} : active_chan + CH_W'(1);
    end else begin
      chan_nxt = active_chan;
    end
    diff = (chan_nxt != active_chan);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if ((step_up || step_dn) && (CH_W'(c) == active_chan)) begin
        wave_nxt[c] = wave_step(wave[c], step_up);
      end else begin
        wave_nxt[c] = wave[c];
      end
      diff = diff | (wave_nxt[c] != wave[c]);
    end
  end

  // Waveform registers, active channel and the change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wave[c] <= WAVE_W'(SQUARE);
      end
      active_chan <= {CH_W{1'b0}};
      changed     <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wave[c] <= wave_nxt[c];
      end
      active_chan <= chan_nxt;
      changed     <= diff;
    end
  end

  // Pack the register array onto the output bus.
  always_comb begin
    waveform_out = {NUM_CHANNELS*WAVE_W{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      waveform_out[c*WAVE_W +: WAVE_W] = wave[c];
    end
  end

endmodule
